// File: rtl/ahbl_sram_ctrl.sv
// AHB-Lite subordinate for a synchronous active-low SRAM: zero-wait reads, posted one-entry writes.
// Optional misaligned-access error response: define AHBL_SRAM_CTRL_ERR_UNALIGNED_EN.
module ahbl_sram_ctrl #(
    parameter int unsigned W_ADDR = 32,
    parameter int unsigned DEPTH  = 512,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ahbls_hready,
    output logic              ahbls_hready_resp,
    output logic              ahbls_hresp,
    input  logic [W_ADDR-1:0] ahbls_haddr,
    input  logic              ahbls_hwrite,
    input  logic [1:0]        ahbls_htrans,
    input  logic [2:0]        ahbls_hsize,
    input  logic [31:0]       ahbls_hwdata,
    output logic [31:0]       ahbls_hrdata,
    output logic              sram_cs_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n,
    output logic [AW-1:0]     sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    logic          aph;
    logic          aph_rd;
    logic          aph_wr;
    logic          misaligned;
    logic [AW-1:0] aph_addr;
    logic [3:0]    aph_mask;

    // Data-phase tracking
    logic          wdph_q, wdph_d;
    logic          rdph_q, rdph_d;
    logic [AW-1:0] wdph_addr_q;
    logic [3:0]    wdph_mask_q;
    logic [AW-1:0] rdph_addr_q;

    // One-entry write buffer
    logic          wbuf_valid_q, wbuf_valid_d;
    logic [AW-1:0] wbuf_addr_q;
    logic [3:0]    wbuf_mask_q;
    logic [31:0]   wbuf_data_q;
    logic          wbuf_load;
    logic          wbuf_retire;
    logic          rd_hit;

    // Upper address bits alias; htrans[0] (SEQ vs NONSEQ) does not matter here.
    logic unused_bits;
    assign unused_bits = ^{ahbls_haddr[W_ADDR-1:AW+2], ahbls_htrans[0]};

    assign aph      = ahbls_hready & ahbls_htrans[1];
    assign aph_addr = ahbls_haddr[2 +: AW];

    always_comb begin
        unique case (ahbls_hsize)
            3'd0:    aph_mask = 4'b0001 << ahbls_haddr[1:0];
            3'd1:    aph_mask = ahbls_haddr[1] ? 4'b1100 : 4'b0011;
            default: aph_mask = 4'b1111;
        endcase
    end

`ifdef AHBL_SRAM_CTRL_ERR_UNALIGNED_EN
    typedef enum logic [1:0] {StIdle, StErr1, StErr2} err_state_e;

    err_state_e err_q, err_d;

    assign misaligned = ((ahbls_hsize == 3'd1) & ahbls_haddr[0])
                      | ((ahbls_hsize == 3'd2) & (|ahbls_haddr[1:0]))
                      | (ahbls_hsize > 3'd2);

    // ERR2 accepts a new address phase, which may itself start another error.
    always_comb begin
        err_d = err_q;
        unique case (err_q)
            StErr1:  err_d = StErr2;
            default: err_d = (aph & misaligned) ? StErr1 : StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= StIdle;
        end else begin
            err_q <= err_d;
        end
    end

    assign ahbls_hready_resp = (err_q != StErr1);
    assign ahbls_hresp       = (err_q != StIdle);
`else
    assign misaligned        = 1'b0;
    assign ahbls_hready_resp = 1'b1;
    assign ahbls_hresp       = 1'b0;
`endif

    assign aph_rd = aph & ~ahbls_hwrite & ~misaligned;
    assign aph_wr = aph &  ahbls_hwrite & ~misaligned;

    // SRAM arbitration: a read address phase always wins over the buffered write.
    always_comb begin
        sram_cs_n = 1'b1;
        sram_we_n = 1'b1;
        sram_be_n = ~wbuf_mask_q;
        sram_addr = wbuf_addr_q;
        if (aph_rd) begin
            sram_cs_n = 1'b0;
            sram_be_n = 4'b0000;
            sram_addr = aph_addr;
        end else if (wbuf_valid_q) begin
            sram_cs_n = 1'b0;
            sram_we_n = 1'b0;
        end
    end

    assign sram_wdata  = wbuf_data_q;
    assign wbuf_retire = wbuf_valid_q & ~aph_rd;
    assign wbuf_load   = wdph_q & ahbls_hready;

    always_comb begin
        wdph_d = wdph_q;
        rdph_d = rdph_q;
        if (ahbls_hready) begin
            wdph_d = aph_wr;
            rdph_d = aph_rd;
        end
        // A load and a retire on the same edge: old entry goes to SRAM, new one takes its place.
        wbuf_valid_d = wbuf_valid_q;
        if (wbuf_load) begin
            wbuf_valid_d = 1'b1;
        end else if (wbuf_retire) begin
            wbuf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdph_q       <= 1'b0;
            rdph_q       <= 1'b0;
            wbuf_valid_q <= 1'b0;
            wdph_addr_q  <= '0;
            wdph_mask_q  <= '0;
            rdph_addr_q  <= '0;
            wbuf_addr_q  <= '0;
            wbuf_mask_q  <= '0;
            wbuf_data_q  <= '0;
        end else begin
            wdph_q       <= wdph_d;
            rdph_q       <= rdph_d;
            wbuf_valid_q <= wbuf_valid_d;
            if (aph_wr) begin
                wdph_addr_q <= aph_addr;
                wdph_mask_q <= aph_mask;
            end
            if (aph_rd) begin
                rdph_addr_q <= aph_addr;
            end
            if (wbuf_load) begin
                wbuf_addr_q <= wdph_addr_q;
                wbuf_mask_q <= wdph_mask_q;
                wbuf_data_q <= ahbls_hwdata;
            end
        end
    end

    // Bytewise merge so a read never sees data older than the buffered write.
    assign rd_hit = rdph_q & wbuf_valid_q & (wbuf_addr_q == rdph_addr_q);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            ahbls_hrdata[8*i +: 8] = (rd_hit & wbuf_mask_q[i]) ? wbuf_data_q[8*i +: 8]
                                                               : sram_rdata[8*i +: 8];
        end
    end

endmodule
